// File: rtl/sprite_mover_if.sv
// sprite_mover_if
//   Bundles the keycode-side inputs and sprite-side outputs of sprite_mover.
//   master : keycode source / consumer of sprite state (drives en, keycode)
//   slave  : sprite_mover itself (drives PosX, PosY, Size, Dir, moving, hit_wall)
//   en       movement enable; 0 freezes all mover state
//   keycode  current USB keycode (0x00 = no key)
//   PosX/Y   sprite centre coordinates, W bits
//   Size     sprite half-extent, constant
//   Dir      0 NONE, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN
//   moving   Dir != NONE
//   hit_wall one-tick pulse on a boundary event
interface sprite_mover_if #(
  parameter int W = 10
);
  logic         en;
  logic [7:0]   keycode;
  logic [W-1:0] PosX;
  logic [W-1:0] PosY;
  logic [W-1:0] Size;
  logic [2:0]   Dir;
  logic         moving;
  logic         hit_wall;

  modport master (
    output en, keycode,
    input  PosX, PosY, Size, Dir, moving, hit_wall
  );

  modport slave (
    input  en, keycode,
    output PosX, PosY, Size, Dir, moving, hit_wall
  );
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover
//   Keyboard-driven sprite position engine. Once every DIV enabled frame_clk
//   edges (a "tick") the keycode is decoded into a direction and the sprite
//   centre moves STEP pixels along that direction. The centre is kept inside
//   [MIN+SIZE, MAX-SIZE] on each axis; leaving that range is a wall event
//   handled by WALL_MODE (0 stop, 1 bounce, 2 wrap) and flagged on hit_wall.
// Ports
//   frame_clk  one rising edge per video frame
//   Reset      asynchronous, active-low
//   bus        sprite_mover_if slave modport (en, keycode in; PosX, PosY,
//              Size, Dir, moving, hit_wall out, all registered except Size)
module sprite_mover #(
  parameter int W         = 10,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int WALL_MODE = 0,
  parameter int DIV       = 1
) (
  input logic           frame_clk,
  input logic           Reset,
  sprite_mover_if.slave bus
);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_e;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // Two extra bits so a step below zero stays negative instead of wrapping.
  localparam logic signed [W+1:0] X_LO   = (W+2)'(X_MIN + SIZE);
  localparam logic signed [W+1:0] X_HI   = (W+2)'(X_MAX - SIZE);
  localparam logic signed [W+1:0] Y_LO   = (W+2)'(Y_MIN + SIZE);
  localparam logic signed [W+1:0] Y_HI   = (W+2)'(Y_MAX - SIZE);
  localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       pos_x_q, pos_x_d;
  logic [W-1:0]       pos_y_q, pos_y_d;
  dir_e               dir_q, dir_d;
  logic               moving_q, moving_d;
  logic               hit_q, hit_d;

  logic               tick;
  dir_e               dir_new;
  logic signed [W+1:0] cand_x, cand_y;

  always_comb begin
    cnt_d   = cnt_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    dir_new = dir_q;
    cand_x  = $signed({2'b00, pos_x_q});
    cand_y  = $signed({2'b00, pos_y_q});
    tick    = bus.en && (cnt_q == CNT_LAST);

    if (bus.en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    if (tick) begin
      // Unrecognised keys keep the current direction; stray encodings act as NONE.
      dir_new = (dir_q > DIR_DOWN) ? DIR_NONE : dir_q;
      case (bus.keycode)
        8'h04:   dir_new = DIR_LEFT;
        8'h07:   dir_new = DIR_RIGHT;
        8'h1A:   dir_new = DIR_UP;
        8'h16:   dir_new = DIR_DOWN;
        8'h29:   dir_new = DIR_NONE;
        default: ;
      endcase

      // The freshly decoded direction moves the sprite on this same tick.
      case (dir_new)
        DIR_LEFT:  cand_x = cand_x - STEP_S;
        DIR_RIGHT: cand_x = cand_x + STEP_S;
        DIR_UP:    cand_y = cand_y - STEP_S;
        DIR_DOWN:  cand_y = cand_y + STEP_S;
        default:   ;
      endcase

      dir_d = dir_new;

      if (cand_x < X_LO) begin
        hit_d = 1'b1;
        case (WALL_MODE)
          1:       begin pos_x_d = X_LO[W-1:0]; dir_d = DIR_RIGHT; end
          2:       pos_x_d = X_HI[W-1:0];
          default: begin pos_x_d = X_LO[W-1:0]; dir_d = DIR_NONE; end
        endcase
      end else if (cand_x > X_HI) begin
        hit_d = 1'b1;
        case (WALL_MODE)
          1:       begin pos_x_d = X_HI[W-1:0]; dir_d = DIR_LEFT; end
          2:       pos_x_d = X_LO[W-1:0];
          default: begin pos_x_d = X_HI[W-1:0]; dir_d = DIR_NONE; end
        endcase
      end else begin
        pos_x_d = cand_x[W-1:0];
      end

      if (cand_y < Y_LO) begin
        hit_d = 1'b1;
        case (WALL_MODE)
          1:       begin pos_y_d = Y_LO[W-1:0]; dir_d = DIR_DOWN; end
          2:       pos_y_d = Y_HI[W-1:0];
          default: begin pos_y_d = Y_LO[W-1:0]; dir_d = DIR_NONE; end
        endcase
      end else if (cand_y > Y_HI) begin
        hit_d = 1'b1;
        case (WALL_MODE)
          1:       begin pos_y_d = Y_HI[W-1:0]; dir_d = DIR_UP; end
          2:       pos_y_d = Y_LO[W-1:0];
          default: begin pos_y_d = Y_HI[W-1:0]; dir_d = DIR_NONE; end
        endcase
      end else begin
        pos_y_d = cand_y[W-1:0];
      end
    end

    moving_d = (dir_d != DIR_NONE);
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      pos_x_q  <= W'(X_CENTER);
      pos_y_q  <= W'(Y_CENTER);
      dir_q    <= DIR_NONE;
      moving_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.PosX     = pos_x_q;
  assign bus.PosY     = pos_y_q;
  assign bus.Size     = W'(SIZE);
  assign bus.Dir      = dir_q;
  assign bus.moving   = moving_q;
  assign bus.hit_wall = hit_q;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised keyboard-driven sprite position engine; successor to the single-speed ball mover.
- Adds configurable bounds, size, step, coordinate width and frame-rate divider.
- Adds three wall policies (stop / bounce / wrap), an explicit stop key and status outputs.
- Sits between the USB keycode source and the colour mapper. Outputs are registered sprite centre, size and status.

Parameters:
W, 10, coordinate width in bits
X_CENTER, 320, reset X position
Y_CENTER, 240, reset Y position
X_MIN, 0, leftmost screen coordinate
X_MAX, 639, rightmost screen coordinate
Y_MIN, 0, topmost screen coordinate
Y_MAX, 479, bottommost screen coordinate
SIZE, 4, sprite half-extent, in pixels
STEP, 1, pixels moved per update tick
WALL_MODE, 0, wall policy: 0 = stop, 1 = bounce, 2 = wrap
DIV, 1, update once every DIV frame_clk edges (DIV >= 1)

Ports:
frame_clk  in  1  clock; one edge per video frame
Reset  in  1  asynchronous, active-low reset (asserted at 0)
en  in  1  movement enable; 0 freezes all state
keycode  in  8  current USB keycode (0x00 = no key)
PosX  out  W  sprite centre X
PosY  out  W  sprite centre Y
Size  out  W  constant SIZE
Dir  out  3  0 = NONE, 1 = LEFT, 2 = RIGHT, 3 = UP, 4 = DOWN
moving  out  1  1 when Dir != NONE
hit_wall  out  1  one-tick pulse on any boundary event

Behaviour:
- Reset (Reset=0, asynchronous), all state cleared:
  - PosX=X_CENTER, PosY=Y_CENTER.
  - Dir=NONE, moving=0, hit_wall=0.
  - Divider count=0.
- Divider:
  - cnt counts 0..DIV-1 on each edge while en=1.
  - tick is asserted when cnt==DIV-1 and en=1; cnt then wraps to 0.
  - en=0: cnt, Pos, Dir held; hit_wall forced to 0.
- Non-tick edges:
  - Pos and Dir hold.
  - hit_wall=0.
  - keycode is ignored; only the tick-edge value is sampled.
- Tick edge, step 1 (direction decode):
  - 0x04 -> LEFT, 0x07 -> RIGHT, 0x1A -> UP, 0x16 -> DOWN.
  - 0x29 -> NONE.
  - Any other value, including 0x00 -> keep current Dir.
- Tick edge, step 2 (candidate):
  - Compute candidate position from the newly decoded Dir in the same tick. A key press moves the sprite on the tick it is sampled; no one-frame lag.
  - Arithmetic is W+2 bits signed, so underflow below 0 is detected correctly.
  - Only one axis moves; the other axis is unchanged.
- Tick edge, step 3 (limits):
  - LO = MIN+SIZE, HI = MAX-SIZE, per axis.
  - If LO <= candidate <= HI: Pos = candidate, hit_wall=0.
- Tick edge, candidate outside [LO,HI] (hit_wall=1 in every mode):
  - Mode 0 (stop): Pos = violated limit, Dir = NONE.
  - Mode 1 (bounce): Pos = violated limit, Dir reversed (LEFT<->RIGHT, UP<->DOWN).
  - Mode 2 (wrap): Pos = opposite limit, Dir unchanged.
- Landing exactly on LO or HI is not a wall event; the event fires on the next tick that tries to pass the limit.
- Outputs:
  - moving = (Dir != NONE), registered with Dir.
  - Size is constant.
  - Dir encodings 5..7 are unreachable; if present, treat as NONE.
- Reset asserted mid-movement overrides everything immediately and asynchronously. Release takes effect on the next edge, with cnt starting at 0.

Test Plan:
1. Reset low, then release, defaults: PosX=320, PosY=240, Dir=0, moving=0, hit_wall=0. Hold keycode=0x07 for 3 edges -> PosX=321, 322, 323, Dir=2 from the first edge.
2. STEP=4, mode 0, hold 0x07:
   - after 78 ticks PosX=632;
   - next tick PosX=635 (clamped), hit_wall=1 for one edge, Dir=0;
   - following tick PosX stays 635, hit_wall=0.
3. Mode 1, STEP=1, PosX reaches 635 via 0x07, keycode then 0x00:
   - next tick PosX=635, hit_wall=1, Dir=1;
   - following ticks 634, 633.
   Mode 2, same setup: next tick PosX=4, hit_wall=1, Dir=2; then 5.
4. DIV=4, keycode=0x16 -> PosY steps 240 -> 241 only on edges 4, 8, 12. Drop en for 5 edges -> PosY and cnt frozen; movement resumes exactly where it stopped.
5. Moving RIGHT at PosX=330:
   - apply 0x1A for one tick -> PosY=239, PosX=330, Dir=3;
   - then 0x00 -> keeps moving up;
   - 0x29 -> Dir=0 and Pos holds.
6. Moving, then drive Reset=0 between clock edges -> outputs return to 320/240/NONE before the next edge. Release -> first tick occurs DIV edges later.
